sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param.sv | 117 +++++++++++
 tb/tb_sync_fifo_param.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered read data, occupancy count and threshold flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to enable the sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       err_clr,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_dout;

  logic w_empty;
  logic w_full;
  logic w_pushOk;
  logic w_popOk;

  // Acceptance is judged from the pre-edge occupancy only, independently per side.
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == DEPTH_CNT);
  assign w_pushOk = push & ~w_full;
  assign w_popOk  = pop & ~w_empty;

  // Storage has no reset; stale words are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_pushOk) begin
      r_mem[r_wrPtr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_dout  <= '0;
    end else begin
      if (w_pushOk) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_popOk) begin
        r_rdPtr <= r_rdPtr + AW'(1);
        r_dout  <= r_mem[r_rdPtr];
      end
      case ({w_pushOk, w_popOk})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout         = r_dout;
  assign count        = r_count;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_empty = (r_count <= AE_CNT);
  assign almost_full  = (r_count >= AF_CNT);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // A new rejection in the same cycle as err_clr wins, so no event is lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (push && w_full) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (pop && w_empty) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  logic w_unusedErrClr;

  assign w_unusedErrClr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomized and directed bench for sync_fifo_param against a queue-based reference model.
// Expected error flags follow SYNC_FIFO_ERR_FLAGS_EN just like the design.
module tb_sync_fifo_param;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 16;
  localparam int AF_LEVEL = DEPTH - 2;
  localparam int AE_LEVEL = 2;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rstn;
  logic              push;
  logic [DATA_W-1:0] din;
  logic              pop;
  logic [DATA_W-1:0] dout;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [CW-1:0]     count;
  logic              err_clr;
  logic              overflow;
  logic              underflow;

  int errorCount = 0;
  int checkCount = 0;

  logic [DATA_W-1:0] modelQ [$];
  logic [DATA_W-1:0] expDout;
  logic              expOvf;
  logic              expUnf;

  sync_fifo_param #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .AF_LEVEL(AF_LEVEL),
    .AE_LEVEL(AE_LEVEL)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .push        (push),
    .din         (din),
    .pop         (pop),
    .dout        (dout),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .count       (count),
    .err_clr     (err_clr),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Everything observable is derived from the occupancy of the model queue.
  task automatic checkState(input string tag);
    int occ;
    occ = modelQ.size();
    checkOutput({tag, "_count"}, 32'(count), 32'(occ));
    checkOutput({tag, "_dout"}, 32'(dout), 32'(expDout));
    checkOutput({tag, "_empty"}, 32'(empty), 32'(occ == 0));
    checkOutput({tag, "_full"}, 32'(full), 32'(occ == DEPTH));
    checkOutput({tag, "_aempty"}, 32'(almost_empty), 32'(occ <= AE_LEVEL));
    checkOutput({tag, "_afull"}, 32'(almost_full), 32'(occ >= AF_LEVEL));
    checkOutput({tag, "_ovf"}, 32'(overflow), 32'(expOvf));
    checkOutput({tag, "_unf"}, 32'(underflow), 32'(expUnf));
  endtask

  task automatic applyStimulus(input string tag, input logic doPush, input logic [DATA_W-1:0] data,
                               input logic doPop, input logic doClr);
    logic pushOk;
    logic popOk;
    @(negedge clk);
    push    = doPush;
    din     = data;
    pop     = doPop;
    err_clr = doClr;
    pushOk  = doPush && (modelQ.size() < DEPTH);
    popOk   = doPop && (modelQ.size() > 0);
    if (popOk) expDout = modelQ.pop_front();
    if (pushOk) modelQ.push_back(data);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    if (doPush && !pushOk) expOvf = 1'b1;
    else if (doClr) expOvf = 1'b0;
    if (doPop && !popOk) expUnf = 1'b1;
    else if (doClr) expUnf = 1'b0;
`endif
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    err_clr = 1'b0;
    checkState(tag);
  endtask

  // Reset is asserted between edges so its effect must be visible without a clock.
  task automatic doReset(input string tag);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    modelQ.delete();
    expDout = '0;
    expOvf  = 1'b0;
    expUnf  = 1'b0;
    #1;
    checkState(tag);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn    = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    din     = '0;
    err_clr = 1'b0;
    expDout = '0;
    expOvf  = 1'b0;
    expUnf  = 1'b0;
    #3;
    checkState("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Basic order and one-cycle read latency.
    applyStimulus("p11", 1'b1, 8'h11, 1'b0, 1'b0);
    applyStimulus("p22", 1'b1, 8'h22, 1'b0, 1'b0);
    applyStimulus("p33", 1'b1, 8'h33, 1'b0, 1'b0);
    applyStimulus("p44", 1'b1, 8'h44, 1'b0, 1'b0);
    applyStimulus("pop1", 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("basic_first", 32'(dout), 32'h11);
    applyStimulus("pop2", 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("basic_second", 32'(dout), 32'h22);
    checkOutput("basic_count", 32'(count), 32'd2);

    // Fill to full, attempt overflow, drain in order.
    doReset("rst_fill");
    for (int i = 0; i < DEPTH; i++) applyStimulus("fill", 1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    checkOutput("fill_full", 32'(full), 32'd1);
    applyStimulus("ovf_push", 1'b1, 8'h99, 1'b0, 1'b0);
    checkOutput("ovf_count", 32'(count), 32'(DEPTH));
    applyStimulus("ovf_both", 1'b1, 8'h98, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus("drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Underflow, clear, and pop+push at empty.
    applyStimulus("unf_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus("unf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus("unf_both", 1'b1, 8'h77, 1'b1, 1'b0);
    applyStimulus("unf_last", 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus("unf_setclr", 1'b0, 8'h00, 1'b1, 1'b1);

    // Pointer wrap-around.
    doReset("rst_wrap");
    for (int i = 0; i < DEPTH; i++) applyStimulus("wrap_fill", 1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus("wrap_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus("wrap_push", 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus("wrap_drain", 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("wrap_empty", 32'(empty), 32'd1);

    // Steady-state simultaneous push/pop.
    doReset("rst_pp");
    for (int i = 0; i < 5; i++) applyStimulus("pp_fill", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("pp_both", 1'b1, 8'(8'hD0 + i), 1'b1, 1'b0);
      checkOutput("pp_count", 32'(count), 32'd5);
    end

    // Asynchronous reset mid-operation.
    doReset("rst_mid0");
    for (int i = 0; i < 7; i++) applyStimulus("mid_fill", 1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
    applyStimulus("mid_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus("mid_push", 1'b1, 8'hEF, 1'b0, 1'b0);
    checkOutput("mid_count7", 32'(count), 32'd7);
    doReset("rst_mid");
    applyStimulus("mid_resume", 1'b1, 8'h3C, 1'b0, 1'b0);
    applyStimulus("mid_resume_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic with a push bias that moves between phases.
    for (int phase = 0; phase < 12; phase++) begin
      int pushPct;
      pushPct = (phase % 3 == 0) ? 80 : ((phase % 3 == 1) ? 20 : 50);
      for (int i = 0; i < 150; i++) begin
        applyStimulus("rand",
                      1'($urandom_range(0, 99) < pushPct),
                      8'($urandom),
                      1'($urandom_range(0, 99) < (100 - pushPct)),
                      1'($urandom_range(0, 99) < 5));
      end
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
